// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a serializer, zero-gap back-to-back frames.
// Optional even parity bit (8E1) when UART_TX_PARITY_EN is defined.
module uart_tx_buffered #(
    parameter int unsigned CLOCK_FREQ = 90_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    data_in,
    input  logic                          data_in_valid,
    output logic                          data_in_ready,
    output logic                          serial_out,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned CW = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned NW = PW + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            serial_q, serial_d;
    logic            busy_q, busy_d;
    logic            ready_q, ready_d;
    logic [NW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
`ifdef UART_TX_PARITY_EN
    logic            parity_q, parity_d;
`endif
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic            push;
    logic            pop;
    logic            load;
    logic            empty;
    logic            cnt_last;
    logic [7:0]      head;

    assign push     = data_in_valid && ready_q;
    assign empty    = (count_q == '0);
    assign cnt_last = (cnt_q == CW'(SYMBOL_EDGE_TIME - 1));
    assign head     = mem_q[rd_ptr_q];

    // Next-state, FIFO bookkeeping and registered-output values
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        serial_d = serial_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        load     = 1'b0;
        pop      = 1'b0;

        case (state_q)
            IDLE: begin
                serial_d = 1'b1;
                load     = !empty;
            end
            START: begin
                if (cnt_last) begin
                    cnt_d    = '0;
                    state_d  = DATA;
                    serial_d = shift_q[0];
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d  = PARITY;
                        serial_d = parity_q;
`else
                        state_d  = STOP;
                        serial_d = 1'b1;
`endif
                    end else begin
                        bit_d    = bit_q + 3'd1;
                        shift_d  = {1'b0, shift_q[7:1]};
                        serial_d = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (cnt_last) begin
                    cnt_d    = '0;
                    state_d  = STOP;
                    serial_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            STOP: begin
                if (cnt_last) begin
                    cnt_d    = '0;
                    state_d  = IDLE;
                    serial_d = 1'b1;
                    load     = !empty;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                serial_d = 1'b1;
            end
        endcase

        // Pop the head straight into the start bit so frames run back-to-back
        if (load) begin
            pop      = 1'b1;
            shift_d  = head;
            cnt_d    = '0;
            bit_d    = '0;
            state_d  = START;
            serial_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d = ^head;
`endif
        end

        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + NW'(push) - NW'(pop);
        ready_d  = (count_d != NW'(FIFO_DEPTH));
        busy_d   = (state_d != IDLE) || (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Storage needs no reset: pointers define which entries are live
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign data_in_ready = ready_q;
    assign serial_out    = serial_q;
    assign tx_busy       = busy_q;
    assign fifo_count    = count_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Randomized scoreboard bench for uart_tx_buffered (10 cycles/bit); honours UART_TX_PARITY_EN.
module tb_uart_tx_buffered;

    localparam int unsigned CLOCK_FREQ = 1000;
    localparam int unsigned BAUD_RATE  = 100;
    localparam int unsigned DEPTH      = 8;
    localparam int          SET        = CLOCK_FREQ / BAUD_RATE;
`ifdef UART_TX_PARITY_EN
    localparam int          NBITS      = 11;
`else
    localparam int          NBITS      = 10;
`endif
    localparam int          FRAME_CYC  = NBITS * SET;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [7:0]               data_in;
    logic                     data_in_valid;
    logic                     data_in_ready;
    logic                     serial_out;
    logic                     tx_busy;
    logic [$clog2(DEPTH):0]   fifo_count;

    int nvec = 0;
    int nerr = 0;

    uart_tx_buffered #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .serial_out    (serial_out),
        .tx_busy       (tx_busy),
        .fifo_count    (fifo_count)
    );

    always #5 clk = ~clk;

    // Reference model: buffered bytes, current frame byte and remaining frame cycles
    logic [7:0] m_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] m_cur = 8'h00;
    int         m_left = 0;
    bit         started = 1'b0;
    int         peak = 0;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_serial();
        int pos;
        int b;
        if (m_left == 0) return 1;
        pos = FRAME_CYC - m_left;
        b   = pos / SET;
        if (b == 0) return 0;
        if (b <= 8) return int'(m_cur[b-1]);
`ifdef UART_TX_PARITY_EN
        if (b == 9) return int'(^m_cur);
`endif
        return 1;
    endfunction

    always @(posedge clk) begin
        bit         full_pre;
        bit         do_pop;
        logic [7:0] b;
        started = 1'b1;
        if (rst) begin
            m_q.delete();
            exp_q.delete();
            m_left = 0;
        end else begin
            full_pre = (m_q.size() >= DEPTH);
            do_pop   = (m_left <= 1) && (m_q.size() > 0);
            if (m_left > 0) m_left--;
            if (do_pop) begin
                b = m_q.pop_front();
                m_cur  = b;
                m_left = FRAME_CYC;
                exp_q.push_back(b);
            end
            if (data_in_valid && !full_pre) m_q.push_back(data_in);
        end
    end

    // Cycle-level comparison of every output against the model
    always @(negedge clk) begin
        if (started) begin
            chk("serial_out", int'(serial_out), exp_serial());
            chk("data_in_ready", int'(data_in_ready), int'(m_q.size() < DEPTH));
            chk("tx_busy", int'(tx_busy), int'((m_left > 0) || (m_q.size() > 0)));
            chk("fifo_count", int'(fifo_count), m_q.size());
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
    end

    // Line receiver: decodes frames mid-bit and pops the expected-byte scoreboard
    bit         rx_act = 1'b0;
    int         rx_t = 0;
    logic [7:0] rx_byte = 8'h00;
    always @(negedge clk) begin
        int   b;
        logic e;
        if (!started || rst) begin
            rx_act = 1'b0;
        end else if (!rx_act) begin
            if (serial_out == 1'b0) begin
                rx_act = 1'b1;
                rx_t   = 0;
            end
        end else begin
            rx_t++;
        end
        if (rx_act && (rx_t % SET) == SET / 2) begin
            b = rx_t / SET;
            if (b == 0) begin
                chk("rx_start_bit", int'(serial_out), 0);
            end else if (b <= 8) begin
                rx_byte[b-1] = serial_out;
`ifdef UART_TX_PARITY_EN
            end else if (b == 9) begin
                chk("rx_parity", int'(serial_out), int'(^rx_byte));
`endif
            end else begin
                chk("rx_stop_bit", int'(serial_out), 1);
                if (exp_q.size() == 0) begin
                    chk("rx_unexpected_frame", int'(rx_byte), -1);
                end else begin
                    e = 1'b0;
                    chk("rx_byte", int'(rx_byte), int'(exp_q.pop_front()));
                end
                rx_act = 1'b0;
            end
        end
    end

    task automatic drive(input logic v, input logic [7:0] d);
        data_in_valid = v;
        data_in       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        data_in_valid = 1'b0;
        while ((m_left != 0 || m_q.size() != 0) && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 5000) chk({name, "_drain_timeout"}, n, 0);
        repeat (3) drive(1'b0, 8'h00);
    endtask

    task automatic wait_pos(input int pos, input string name);
        int n = 0;
        while (m_left != FRAME_CYC - pos && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 5000) chk({name, "_wait_timeout"}, n, 0);
    endtask

    initial begin
        rst           = 1'b1;
        data_in_valid = 1'b0;
        data_in       = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_serial_out", int'(serial_out), 1);
        chk("reset_fifo_count", int'(fifo_count), 0);

        drive(1'b1, 8'hA5);
        drive(1'b0, 8'h00);
        wait_idle("single");

        peak = 0;
        drive(1'b1, 8'h00);
        drive(1'b1, 8'hFF);
        drive(1'b1, 8'h55);
        wait_idle("b2b");
        chk("b2b_peak_count", peak, 2);

        for (int i = 0; i < 12; i++) drive(1'b1, 8'(8'h10 + i));
        wait_idle("full");

        // Four pushes leave three buffered, then push on the stop-completion edge
        for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h60 + i));
        data_in_valid = 1'b0;
        wait_pos(FRAME_CYC - 1, "simul");
        drive(1'b1, 8'h6A);
        chk("simul_count_held", int'(fifo_count), 3);
        wait_idle("simul");

        for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'h80 + i));
        data_in_valid = 1'b0;
        wait_pos(5 * SET + 5, "rst_mid");
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_serial_out", int'(serial_out), 1);
        chk("rst_fifo_count", int'(fifo_count), 0);
        chk("rst_tx_busy", int'(tx_busy), 0);
        repeat (3 * FRAME_CYC) drive(1'b0, 8'h00);

        drive(1'b1, 8'h07);
        drive(1'b1, 8'h03);
        wait_idle("parity");

        for (int i = 0; i < 1500; i++) begin
            if ((i / 100) % 2 == 0) drive(($urandom_range(0, 3) == 0), 8'($urandom));
            else                    drive(($urandom_range(0, 99) == 0), 8'($urandom));
        end
        wait_idle("random");
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
